// File: rtl/cpu_if_sched.sv
// cpu_if_sched: round-robin scheduler of NREQ requesters onto one CPU-interface target with a per-access watchdog
//   clk, reset_l      : clock, asynchronous active-low reset
//   cfg_timeout       : watchdog window in cycles, 0 disables it
//   req / gnt / done  : per-requester request level, one-hot grant, one-hot completion pulse
//   bus_valid/bus_ack : access active at the target / target completion
//   err               : qualifies done, 1 = aborted by watchdog
//   cpu_if_timeout    : one-cycle pulse per aborted access
//   tmo_count         : saturating count of aborts since reset
module cpu_if_sched #(
    parameter int NREQ  = 4,
    parameter int TMO_W = 8
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic [TMO_W-1:0] cfg_timeout,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic             bus_valid,
    input  logic             bus_ack,
    output logic [NREQ-1:0]  done,
    output logic             err,
    output logic             cpu_if_timeout,
    output logic [7:0]       tmo_count
);
    localparam int PW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    sel;
    logic             any;
    logic [TMO_W-1:0] cnt;
    logic             tmo_hit;
    // Scan downward so the last hit kept is the nearest requester after ptr.
    always_comb begin
        sel = ptr;
        any = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            if (req[(int'(ptr) + i) % NREQ]) begin
                sel = PW'((int'(ptr) + i) % NREQ);
                any = 1'b1;
            end
        end
    end
    assign tmo_hit = (cfg_timeout != '0) && (cnt == cfg_timeout - 1'b1);
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state          <= IDLE;
            ptr            <= PW'(NREQ - 1);
            cnt            <= '0;
            gnt            <= '0;
            bus_valid      <= 1'b0;
            done           <= '0;
            err            <= 1'b0;
            cpu_if_timeout <= 1'b0;
            tmo_count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done           <= '0;
                    err            <= 1'b0;
                    cpu_if_timeout <= 1'b0;
                    if (any) begin
                        state     <= BUSY;
                        gnt       <= NREQ'(1) << sel;
                        bus_valid <= 1'b1;
                        cnt       <= '0;
                        ptr       <= sel;
                    end
                end
                BUSY: begin
                    // An ack in the watchdog's final cycle still completes cleanly.
                    if (bus_ack || tmo_hit) begin
                        state          <= RESP;
                        gnt            <= '0;
                        bus_valid      <= 1'b0;
                        done           <= gnt;
                        err            <= !bus_ack;
                        cpu_if_timeout <= !bus_ack;
                        if (!bus_ack && tmo_count != 8'hff) tmo_count <= tmo_count + 8'd1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    done           <= '0;
                    err            <= 1'b0;
                    cpu_if_timeout <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
